// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  localparam logic [3:0] BE_ALL = 4'hF;
  localparam int         CNT_W  = 4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] max_v);
    return (v >= max_v) ? max_v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory ports around the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import mem_arb_pkg::*;

  logic              instr_req;
  logic [ADDR_W-1:0] instr_adr;
  logic              instr_gnt;
  logic              instr_r_valid;
  logic [DATA_W-1:0] instr_read;

  logic              data_req;
  logic [ADDR_W-1:0] data_adr;
  logic              data_we;
  logic [3:0]        data_be;
  logic [DATA_W-1:0] data_write;
  logic              data_gnt;
  logic              data_r_valid;
  logic [DATA_W-1:0] data_read;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_adr;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_r_valid;
  logic [DATA_W-1:0] mem_rdata;

  state_e            dbg_state;
  owner_e            dbg_owner;
  logic [CNT_W-1:0]  dbg_starve;

  // Handshake: a requester holds req (and its payload) until the cycle gnt is
  // high; gnt is a single-cycle pulse, r_valid pulses once per granted request
  // and read data is only non-zero while r_valid is high.
  modport slave (
    input  instr_req, instr_adr,
    output instr_gnt, instr_r_valid, instr_read,
    input  data_req, data_adr, data_we, data_be, data_write,
    output data_gnt, data_r_valid, data_read,
    output mem_req, mem_adr, mem_we, mem_be, mem_wdata,
    input  mem_gnt, mem_r_valid, mem_rdata,
    output dbg_state, dbg_owner, dbg_starve
  );

  modport master (
    output instr_req, instr_adr,
    input  instr_gnt, instr_r_valid, instr_read,
    output data_req, data_adr, data_we, data_be, data_write,
    input  data_gnt, data_r_valid, data_read,
    input  mem_req, mem_adr, mem_we, mem_be, mem_wdata,
    output mem_gnt, mem_r_valid, mem_rdata,
    input  dbg_state, dbg_owner, dbg_starve
  );

endinterface

// File: rtl/mem_arb_prio.sv
// Winner select (data first) with a saturating counter that bounds fetch starvation.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_WINS = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             instr_req_i,
  input  logic             data_req_i,
  input  logic             arb_i,
  output owner_e           win_o,
  output logic [CNT_W-1:0] starve_cnt_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DATA_WINS);

  logic [CNT_W-1:0] starve_q, starve_d;

  always_comb begin
    win_o = OWN_NONE;
    if (data_req_i && !(instr_req_i && (starve_q == MAX_CNT))) begin
      win_o = OWN_DATA;
    end else if (instr_req_i) begin
      win_o = OWN_INSTR;
    end
  end

  // Counts only data wins that actually held off a waiting fetch.
  always_comb begin
    starve_d = starve_q;
    if (arb_i) begin
      if ((win_o == OWN_DATA) && instr_req_i) begin
        starve_d = sat_inc(starve_q, MAX_CNT);
      end else begin
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign starve_cnt_o = starve_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one req/gnt/r_valid memory port between fetch and load/store,
// one transaction in flight, response routed back to the owning requester.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DATA_WINS = 4
) (
  input  logic          CLK,
  input  logic          RES,
  mem_arbiter_if.slave  bus
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              arb;
  owner_e            win;
  logic [CNT_W-1:0]  starve_cnt;

  logic              instr_gnt, data_gnt;
  logic              instr_r_valid, data_r_valid;
  logic [DATA_W-1:0] instr_read, data_read;

  // Re-arbitration in RESP lets the next request issue without an IDLE bubble.
  assign arb = (state_q == IDLE) || ((state_q == RESP) && bus.mem_r_valid);

  mem_arb_prio #(
    .MAX_DATA_WINS (MAX_DATA_WINS)
  ) u_prio (
    .clk_i        (CLK),
    .rst_ni       (RES),
    .instr_req_i  (bus.instr_req),
    .data_req_i   (bus.data_req),
    .arb_i        (arb),
    .win_o        (win),
    .starve_cnt_o (starve_cnt)
  );

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    adr_d         = adr_q;
    we_d          = we_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    instr_gnt     = 1'b0;
    data_gnt      = 1'b0;
    instr_r_valid = 1'b0;
    data_r_valid  = 1'b0;
    instr_read    = '0;
    data_read     = '0;

    case (state_q)
      IDLE: ;
      REQ: begin
        if (bus.mem_gnt) begin
          instr_gnt = (owner_q == OWN_INSTR);
          data_gnt  = (owner_q == OWN_DATA);
          state_d   = RESP;
        end
      end
      RESP: begin
        if (bus.mem_r_valid) begin
          if (owner_q == OWN_INSTR) begin
            instr_r_valid = 1'b1;
            instr_read    = bus.mem_rdata;
          end
          if (owner_q == OWN_DATA) begin
            data_r_valid = 1'b1;
            data_read    = bus.mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (arb) begin
      case (win)
        OWN_INSTR: begin
          state_d = REQ;
          owner_d = OWN_INSTR;
          adr_d   = bus.instr_adr;
          we_d    = 1'b0;
          be_d    = BE_ALL;
          wdata_d = '0;
        end
        OWN_DATA: begin
          state_d = REQ;
          owner_d = OWN_DATA;
          adr_d   = bus.data_adr;
          we_d    = bus.data_we;
          be_d    = bus.data_be;
          wdata_d = bus.data_write;
        end
        default: begin
          state_d = IDLE;
          owner_d = OWN_NONE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      adr_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.mem_req       = (state_q == REQ);
  assign bus.mem_adr       = adr_q;
  assign bus.mem_we        = we_q;
  assign bus.mem_be        = be_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.instr_gnt     = instr_gnt;
  assign bus.data_gnt      = data_gnt;
  assign bus.instr_r_valid = instr_r_valid;
  assign bus.data_r_valid  = data_r_valid;
  assign bus.instr_read    = instr_read;
  assign bus.data_read     = data_read;
  assign bus.dbg_state     = state_q;
  assign bus.dbg_owner     = owner_q;
  assign bus.dbg_starve    = starve_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXW = 4;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RES = 1'b0;
  always #5 CLK = ~CLK;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_WINS(MAXW)) dut (
    .CLK (CLK),
    .RES (RES),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A transaction is "open" from the win until its response; "granted" once
  // memory accepted it. Who wins next follows the data-first/starvation rule.
  bit          m_open    = 1'b0;
  bit          m_granted = 1'b0;
  int          m_owner   = 0;      // 0 none, 1 fetch, 2 load/store
  logic [31:0] m_adr     = '0;
  logic        m_we      = 1'b0;
  logic [3:0]  m_be      = '0;
  logic [31:0] m_wdata   = '0;
  int          m_streak  = 0;

  always @(negedge CLK) begin
    bit          in_req, in_resp, iv, dv;
    int          w;
    if (!RES) begin
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_adr", bus.mem_adr, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_be", bus.mem_be, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_gnts", {bus.instr_gnt, bus.data_gnt}, 0);
      chk("rst_r_valids", {bus.instr_r_valid, bus.data_r_valid}, 0);
      chk("rst_reads", bus.instr_read | bus.data_read, 0);
      chk("rst_starve", bus.dbg_starve, 0);
      m_open = 0; m_granted = 0; m_owner = 0; m_streak = 0;
      m_adr = '0; m_we = 0; m_be = '0; m_wdata = '0;
    end else begin
      in_req  = m_open && !m_granted;
      in_resp = m_open && m_granted;
      iv = in_resp && (m_owner == 1) && bus.mem_r_valid;
      dv = in_resp && (m_owner == 2) && bus.mem_r_valid;
      chk("mem_req", bus.mem_req, in_req);
      chk("mem_adr", bus.mem_adr, m_adr);
      chk("mem_we", bus.mem_we, m_we);
      chk("mem_be", bus.mem_be, m_be);
      chk("mem_wdata", bus.mem_wdata, m_wdata);
      chk("instr_gnt", bus.instr_gnt, in_req && (m_owner == 1) && bus.mem_gnt);
      chk("data_gnt", bus.data_gnt, in_req && (m_owner == 2) && bus.mem_gnt);
      chk("instr_r_valid", bus.instr_r_valid, iv);
      chk("instr_read", bus.instr_read, iv ? bus.mem_rdata : 32'h0);
      chk("data_r_valid", bus.data_r_valid, dv);
      chk("data_read", bus.data_read, dv ? bus.mem_rdata : 32'h0);
      chk("starve_cnt", bus.dbg_starve, m_streak);
      if (!m_open || (m_granted && bus.mem_r_valid)) begin
        w = 0;
        if (bus.data_req && !(bus.instr_req && m_streak == MAXW)) w = 2;
        else if (bus.instr_req) w = 1;
        m_streak = (w == 2 && bus.instr_req) ? ((m_streak < MAXW) ? m_streak + 1 : MAXW) : 0;
        if (w == 0) begin
          m_open = 0; m_owner = 0;
        end else begin
          m_open = 1; m_granted = 0; m_owner = w;
          if (w == 1) begin
            m_adr = bus.instr_adr; m_we = 0; m_be = 4'hF; m_wdata = '0;
          end else begin
            m_adr = bus.data_adr; m_we = bus.data_we; m_be = bus.data_be; m_wdata = bus.data_write;
          end
        end
      end else if (in_req && bus.mem_gnt) begin
        m_granted = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_mem(input logic g, input logic rv, input logic [31:0] rd);
    bus.mem_gnt = g; bus.mem_r_valid = rv; bus.mem_rdata = rd;
  endtask

  task automatic set_data(input logic rq, input logic [31:0] a, input logic we,
                          input logic [3:0] be, input logic [31:0] wd);
    bus.data_req = rq; bus.data_adr = a; bus.data_we = we; bus.data_be = be; bus.data_write = wd;
  endtask

  task automatic set_instr(input logic rq, input logic [31:0] a);
    bus.instr_req = rq; bus.instr_adr = a;
  endtask

  // ---------------- scoreboard for grant order ----------------
  logic [1:0] exp_q[$];
  logic [3:0] exp_s[$];

  // ---------------- stimulus ----------------
  initial begin
    bit         gi, gd;
    logic [1:0] got;
    set_instr(0, '0);
    set_data(0, '0, 0, '0, '0);
    set_mem(0, 0, '0);
    repeat (3) tick();
    chk("reset_mem_req", bus.mem_req, 0);
    chk("reset_state", bus.dbg_state, IDLE);
    RES = 1'b1;
    tick();

    // Single fetch
    set_instr(1, 32'h100);
    tick();
    chk("fetch_mem_req", bus.mem_req, 1);
    chk("fetch_mem_adr", bus.mem_adr, 32'h100);
    chk("fetch_mem_be", bus.mem_be, 4'hF);
    chk("fetch_mem_we", bus.mem_we, 0);
    chk("fetch_no_early_gnt", bus.instr_gnt, 0);
    set_mem(1, 0, '0);
    settle();
    chk("fetch_gnt", bus.instr_gnt, 1);
    chk("fetch_data_gnt_quiet", bus.data_gnt, 0);
    tick();
    set_instr(0, '0);
    set_mem(0, 0, '0);
    chk("fetch_resp_no_req", bus.mem_req, 0);
    tick();
    set_mem(0, 1, 32'h00500093);
    settle();
    chk("fetch_r_valid", bus.instr_r_valid, 1);
    chk("fetch_read", bus.instr_read, 32'h00500093);
    chk("fetch_data_quiet", {bus.data_r_valid, bus.data_read}, 0);
    tick();
    set_mem(0, 0, '0);

    // Simultaneous requests: store first, fetch follows without IDLE
    set_instr(1, 32'h300);
    set_data(1, 32'h2000, 1, 4'b0011, 32'hDEADBEEF);
    tick();
    chk("sim_mem_adr", bus.mem_adr, 32'h2000);
    chk("sim_mem_we", bus.mem_we, 1);
    chk("sim_mem_be", bus.mem_be, 4'h3);
    chk("sim_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    set_mem(1, 0, '0);
    settle();
    chk("sim_data_gnt", bus.data_gnt, 1);
    chk("sim_instr_gnt", bus.instr_gnt, 0);
    tick();
    set_data(0, '0, 0, '0, '0);
    set_mem(0, 1, 32'h0);
    settle();
    chk("sim_store_r_valid", bus.data_r_valid, 1);
    chk("sim_instr_r_quiet", bus.instr_r_valid, 0);
    tick();
    chk("sim_fetch_req", bus.mem_req, 1);
    chk("sim_fetch_adr", bus.mem_adr, 32'h300);
    chk("sim_fetch_be", bus.mem_be, 4'hF);
    set_mem(1, 0, '0);
    tick();
    set_instr(0, '0);
    set_mem(0, 1, 32'h11);
    tick();
    set_mem(0, 0, '0);
    tick();

    // Starvation: D,D,D,D,I,D,D,D,D,I
    exp_q = {2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    exp_s = {4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    set_instr(1, 32'h1000);
    set_data(1, 32'h3000, 0, 4'hF, '0);
    set_mem(1, 1, 32'h5A5A5A5A);
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      tick();
      if (bus.instr_gnt || bus.data_gnt) begin
        got = bus.data_gnt ? 2'd2 : 2'd1;
        chk("grant_order", got, exp_q.pop_front());
        chk("starve_at_grant", bus.dbg_starve, exp_s.pop_front());
      end
    end
    chk("grant_order_all_seen", exp_q.size(), 0);
    set_instr(0, '0);
    set_data(0, '0, 0, '0, '0);
    tick();
    tick();
    set_mem(0, 0, '0);
    chk("starve_idle", bus.dbg_state, IDLE);

    // Stray traffic
    set_mem(1, 1, 32'hFFFF);
    tick();
    tick();
    chk("stray_idle_state", bus.dbg_state, IDLE);
    chk("stray_idle_quiet", {bus.instr_gnt, bus.data_gnt, bus.instr_r_valid, bus.data_r_valid}, 0);
    set_data(1, 32'h40, 0, 4'hF, '0);
    set_mem(0, 1, 32'hFFFF);
    tick();
    tick();
    chk("stray_req_state", bus.dbg_state, REQ);
    chk("stray_req_quiet", {bus.data_r_valid, bus.instr_r_valid}, 0);
    set_mem(1, 0, '0);
    settle();
    chk("stray_data_gnt", bus.data_gnt, 1);
    tick();
    set_data(0, '0, 0, '0, '0);
    tick();
    chk("stray_resp_state", bus.dbg_state, RESP);
    chk("stray_resp_quiet", {bus.instr_gnt, bus.data_gnt}, 0);
    set_mem(0, 1, 32'h77);
    tick();
    set_mem(0, 0, '0);

    // Gnt backpressure
    set_instr(1, 32'h500);
    tick();
    set_data(1, 32'h600, 0, 4'h1, '0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_mem_req", bus.mem_req, 1);
      chk("bp_mem_adr", bus.mem_adr, 32'h500);
      chk("bp_no_gnt", {bus.instr_gnt, bus.data_gnt}, 0);
    end
    set_mem(1, 0, '0);
    settle();
    chk("bp_instr_gnt", bus.instr_gnt, 1);
    tick();
    set_instr(0, '0);
    set_mem(0, 0, '0);
    repeat (3) tick();
    chk("bp_hold_adr", bus.mem_adr, 32'h500);
    chk("bp_hold_owner", bus.dbg_owner, OWN_INSTR);
    set_mem(0, 1, 32'hCAFE);
    tick();
    chk("bp_data_next_adr", bus.mem_adr, 32'h600);
    set_mem(1, 0, '0);
    tick();
    set_data(0, '0, 0, '0, '0);
    set_mem(0, 1, 32'h1);
    tick();
    set_mem(0, 0, '0);
    tick();

    // Reset mid-transaction
    set_data(1, 32'h700, 0, 4'hF, '0);
    tick();
    set_mem(1, 0, '0);
    tick();
    set_data(0, '0, 0, '0, '0);
    set_mem(0, 1, 32'hAAAA5555);
    settle();
    chk("rm_pre_r_valid", bus.data_r_valid, 1);
    RES = 1'b0;
    settle();
    chk("rm_r_valid_drop", bus.data_r_valid, 0);
    chk("rm_read_drop", bus.data_read, 0);
    chk("rm_mem_adr", bus.mem_adr, 0);
    tick();
    RES = 1'b1;
    set_mem(0, 0, '0);
    set_data(1, 32'h800, 0, 4'hF, '0);
    tick();
    chk("rm_new_adr", bus.mem_adr, 32'h800);
    chk("rm_no_stale", bus.data_r_valid, 0);
    set_mem(1, 0, '0);
    tick();
    set_data(0, '0, 0, '0, '0);
    set_mem(0, 1, 32'h2);
    tick();
    set_mem(0, 0, '0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      gi = bus.instr_gnt;
      gd = bus.data_gnt;
      @(posedge CLK);
      #1;
      set_mem($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom);
      if (!bus.instr_req || gi) set_instr($urandom_range(0, 2) != 0, $urandom);
      if (!bus.data_req || gd)
        set_data($urandom_range(0, 2) != 0, $urandom, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares a single req/gnt/r_valid memory port between the processor's instruction-fetch requester and its load/store requester. It sits between the processor top level and the unified memory. One transaction is in flight at a time. Data has priority over instruction fetch, and a starvation counter bounds how long fetch can be held off. Response data is routed back to whichever requester owns the current transaction.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MAX_DATA_WINS, 4, consecutive data grants allowed while instr_req is pending before fetch is forced to win (range 1..15)

Ports:
CLK  in  1  clock, rising edge
RES  in  1  reset, asynchronous, active-low
instr_req  in  1  fetch request; held until instr_gnt
instr_adr  in  ADDR_W  fetch address
instr_gnt  out  1  fetch request accepted by memory
instr_r_valid  out  1  fetch response valid
instr_read  out  DATA_W  fetch response data
data_req  in  1  load/store request; held until data_gnt
data_adr  in  ADDR_W  load/store address
data_we  in  1  1 = store
data_be  in  4  byte enables
data_write  in  DATA_W  store data
data_gnt  out  1  load/store accepted
data_r_valid  out  1  load/store response valid (stores included)
data_read  out  DATA_W  load response data
mem_req  out  1  request to memory
mem_adr  out  ADDR_W  registered address
mem_we  out  1  registered write enable
mem_be  out  4  registered byte enables
mem_wdata  out  DATA_W  registered write data
mem_gnt  in  1  memory accepts request
mem_r_valid  in  1  memory response valid
mem_rdata  in  DATA_W  memory response data

Behaviour:
- States: IDLE, REQ, RESP. Owner register: NONE/INSTR/DATA.
- Reset (RES=0, asynchronous): state=IDLE, owner=NONE, starve_cnt=0. All outputs are 0, including mem_* registers. Any in-flight transaction is dropped.
- Arbitration happens in IDLE, and in RESP during the cycle mem_r_valid=1. Winner selection:
  - data_req only -> DATA
  - instr_req only -> INSTR
  - both -> DATA, unless starve_cnt==MAX_DATA_WINS, in which case INSTR
- On arbitration win: latch the winner's adr/we/be/wdata into the mem_* registers, set owner, next state=REQ.
  - Fetch latches we=0, be=4'hF, wdata=0.
- Latency: a request first seen at edge N drives mem_req=1 from cycle N+1.
- REQ: mem_req=1. When mem_gnt=1, the owner's gnt is asserted combinationally in the same cycle, and next state=RESP. The other requester's gnt stays 0.
- RESP: mem_req=0. When mem_r_valid=1:
  - owner's r_valid=1 and owner's read data=mem_rdata, same cycle.
  - The other requester's r_valid and read data stay 0.
  - Re-arbitrate: next state is REQ if any request is pending, else IDLE with owner=NONE.
- instr_read and data_read are 0 whenever the corresponding r_valid is 0.
- starve_cnt (4 bit) updates at each arbitration:
  - +1 when DATA wins with instr_req=1
  - cleared when INSTR wins or when instr_req=0
  - saturates at MAX_DATA_WINS
- Stray events are ignored and not forwarded: mem_r_valid in IDLE or REQ, and mem_gnt in IDLE or RESP.
- Requests are not cancellable. Dropping req before gnt is a protocol violation, and the latched transaction still completes.
- Stores complete only on mem_r_valid; data_r_valid pulses for stores.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding localparams (IDLE=2'd0, REQ=2'd1, RESP=2'd2)
  - owner encoding (NONE, INSTR, DATA)
  - BE_ALL=4'hF
  - counter width
- One natural sub-module, mem_arb_prio: combinational winner select plus the registered starve_cnt. It takes instr_req, data_req, and an arbitrate strobe, and returns the winner. The FSM and mem_* registers remain in mem_arbiter.

Test Plan:
- Reset mid-transaction: assert RES=0 while in RESP -> all outputs 0 immediately; after release a new data_req proceeds normally with no stale r_valid.
- Single fetch: instr_req, adr=0x100, with mem_gnt one cycle after mem_req and mem_r_valid with rdata=0x00500093 two cycles later -> mem_req at N+1, mem_adr=0x100, mem_be=F, mem_we=0; instr_gnt pulses with mem_gnt; instr_r_valid and instr_read=0x00500093; data_* stays 0.
- Simultaneous requests: instr_req and data_req both high, store adr=0x2000, be=4'b0011, wdata=0xDEADBEEF -> data is served first with mem_we=1, mem_be=3, mem_wdata=0xDEADBEEF; on its r_valid, fetch goes straight to REQ with no IDLE cycle.
- Starvation (MAX_DATA_WINS=4): data_req and instr_req held high continuously -> grant order D,D,D,D,I,D,...; starve_cnt returns to 0 after the I grant.
- Stray traffic: mem_r_valid=1 in IDLE and in REQ, and mem_gnt=1 in RESP -> no gnt or r_valid on either requester; state unchanged.
- Gnt backpressure: mem_gnt held low for 10 cycles in REQ -> mem_req and mem_adr stay stable; the pending requester sees no gnt until mem_gnt=1; the other requester's req is not arbitrated until RESP completes.
